// File: rtl/regfile_wb_ctrl.sv
// rtl/regfile_wb_ctrl.sv - round-robin writeback arbiter, pending-write scoreboard and read bypass
// Optional macro RF_WB_BYPASS_EN forwards the registered write to the read ports.
module regfile_wb_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int NUM_REQ    = 2,
    localparam int AW        = $clog2(NUM_REGS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*AW-1:0]         req_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic                          alloc_valid_i,
    input  logic [AW-1:0]                 alloc_addr_i,
    output logic [NUM_REGS-1:0]           reg_busy_o,
    output logic                          wb_we_o,
    output logic [AW-1:0]                 wb_addr_o,
    output logic [DATA_WIDTH-1:0]         wb_data_o,
    input  logic [AW-1:0]                 rd_a1_i,
    input  logic [AW-1:0]                 rd_a2_i,
    input  logic [DATA_WIDTH-1:0]         rf_rd1_i,
    input  logic [DATA_WIDTH-1:0]         rf_rd2_i,
    output logic [DATA_WIDTH-1:0]         byp_rd1_o,
    output logic [DATA_WIDTH-1:0]         byp_rd2_o
);

    localparam int RRW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [RRW-1:0]        rr_q, rr_d;
    logic [NUM_REGS-1:0]   busy_q, busy_d;
    logic                  wb_we_q, wb_we_d;
    logic [AW-1:0]         wb_addr_q, wb_addr_d;
    logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;

    logic [NUM_REQ-1:0]    grant;
    logic                  xfer;
    logic [RRW-1:0]        gnt_idx;
    logic [AW-1:0]         sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    // Scan upward from the pointer with wrap-around; first valid requester wins.
    always_comb begin
        int idx;
        grant    = '0;
        xfer     = 1'b0;
        gnt_idx  = '0;
        sel_addr = '0;
        sel_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!xfer && req_valid_i[idx]) begin
                xfer        = 1'b1;
                grant[idx]  = 1'b1;
                gnt_idx     = RRW'(idx);
                sel_addr    = req_addr_i[idx*AW +: AW];
                sel_data    = req_data_i[idx*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign req_ready_o = grant;

    always_comb begin
        rr_d      = rr_q;
        busy_d    = busy_q;
        wb_we_d   = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        if (xfer) begin
            rr_d      = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + RRW'(1);
            busy_d[sel_addr] = 1'b0;
            wb_we_d   = (sel_addr != '0);
            wb_addr_d = sel_addr;
            wb_data_d = sel_data;
        end
        // Set after clear: a same-cycle allocation belongs to a younger producer.
        if (alloc_valid_i && alloc_addr_i != '0) begin
            busy_d[alloc_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q      <= '0;
            busy_q    <= '0;
            wb_we_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            rr_q      <= rr_d;
            busy_q    <= busy_d;
            wb_we_q   <= wb_we_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign reg_busy_o = busy_q;
    assign wb_we_o    = wb_we_q;
    assign wb_addr_o  = wb_addr_q;
    assign wb_data_o  = wb_data_q;

`ifdef RF_WB_BYPASS_EN
    // Covers the cycle where the file has not yet absorbed the registered write.
    assign byp_rd1_o = (wb_we_q && wb_addr_q == rd_a1_i && rd_a1_i != '0) ? wb_data_q : rf_rd1_i;
    assign byp_rd2_o = (wb_we_q && wb_addr_q == rd_a2_i && rd_a2_i != '0) ? wb_data_q : rf_rd2_i;
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^{rd_a1_i, rd_a2_i};
    assign byp_rd1_o      = rf_rd1_i;
    assign byp_rd2_o      = rf_rd2_i;
`endif

endmodule
